// File: rtl/cache_data_ctrl_pkg.sv
// Shared widths, field layout and FSM states for the data cache.
// Also holds the power-up image of the backing memory.
package cache_data_ctrl_pkg;

    localparam int PA_WIDTH   = 32;
    localparam int WRD_WIDTH  = 32;
    localparam int BYTE       = 8;
    localparam int BLK_WIDTH  = 512;
    localparam int NUM_LINES  = 16;
    localparam int MEM_BLOCKS = 64;

    localparam int OFF_W  = 6;
    localparam int IDX_W  = 4;
    localparam int TAG_W  = PA_WIDTH - OFF_W - IDX_W;
    localparam int WSEL_W = 4;
    localparam int MIDX_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_t;

    // Byte k of block bi holds the low 8 bits of its own address.
    function automatic logic [BLK_WIDTH-1:0] init_blk(
        input logic [MIDX_W-1:0] bi
    );
        logic [BLK_WIDTH-1:0] b;
        b = '0;
        for (int k = 0; k < 64; k++) begin
            b[8*k +: 8] = {bi[1:0], 6'(k)};
        end
        return b;
    endfunction

endpackage

// File: rtl/cache_data_ctrl_mem.sv
// Block-wide synchronous backing store, 4 KiB, aliasing modulo its size.
// Untouched blocks read back the address-pattern image.
module cache_data_ctrl_mem
    import cache_data_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic [PA_WIDTH-1:0]  addr,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [BLK_WIDTH-1:0] wr_data,
    output logic [BLK_WIDTH-1:0] rd_data
);

    logic [BLK_WIDTH-1:0]  blocks [MEM_BLOCKS];
    logic [MEM_BLOCKS-1:0] written = '0;
    logic [MIDX_W-1:0]     bi;
    logic                  unused_addr;

    assign bi = addr[11:6];
    assign unused_addr = ^{addr[PA_WIDTH-1:12], addr[5:0]};

    // Block write and registered block read on the same port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            blocks[bi]  <= wr_data;
            written[bi] <= 1'b1;
        end
        if (rd_en) begin
            rd_data <= written[bi] ? blocks[bi] : init_blk(bi);
        end
    end

endmodule

// File: rtl/cache_data_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Fills and evicts whole 64-byte lines over a block-wide memory port.
module cache_data_ctrl
    import cache_data_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [PA_WIDTH-1:0]  addr,
    input  logic [WRD_WIDTH-1:0] data_wr,
    input  logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic                 hit,
    output logic [WRD_WIDTH-1:0] word_out,
    output logic [BYTE-1:0]      byte_out
);

    state_t state;

    logic [BLK_WIDTH-1:0] data_arr [NUM_LINES];
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;

    logic [PA_WIDTH-1:0]  req_addr;
    logic [WRD_WIDTH-1:0] req_data;
    logic                 req_wr;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [OFF_W-1:0]     boff;
    logic [8:0]           wbit;
    logic [8:0]           bbit;
    logic [4:0]           dbit;
    logic [BLK_WIDTH-1:0] line;
    logic                 is_hit;

    assign idx    = req_addr[9:6];
    assign tag    = req_addr[PA_WIDTH-1:10];
    assign boff   = req_addr[5:0];
    assign wbit   = {boff[5:2], 5'b0};
    assign bbit   = {boff, 3'b0};
    assign dbit   = {boff[1:0], 3'b0};
    assign line   = data_arr[idx];
    assign is_hit = valid[idx] && (tag_arr[idx] == tag);

    // Control FSM with registered result and memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_data   <= '0;
            req_wr     <= 1'b0;
            valid      <= '0;
            dirty      <= '0;
            hit        <= 1'b0;
            word_out   <= '0;
            byte_out   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wr_blk <= '0;
        end else begin
            hit        <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wr_blk <= '0;
            unique case (state)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        req_addr <= addr;
                        req_data <= data_wr;
                        req_wr   <= wr_en;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (is_hit) begin
                        hit   <= 1'b1;
                        state <= IDLE;
                        if (req_wr) begin
                            word_out   <= req_data;
                            byte_out   <= req_data[dbit +: 8];
                            dirty[idx] <= 1'b1;
                        end else begin
                            word_out <= line[wbit +: 32];
                            byte_out <= line[bbit +: 8];
                        end
                    end else if (valid[idx] && dirty[idx]) begin
                        mem_wr_en  <= 1'b1;
                        mem_addr   <= {tag_arr[idx], idx, 6'b0};
                        mem_wr_blk <= line;
                        state      <= WRITEBACK;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= {req_addr[PA_WIDTH-1:6], 6'b0};
                        state     <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= {req_addr[PA_WIDTH-1:6], 6'b0};
                    state     <= ALLOCATE;
                end
                ALLOCATE: begin
                    state <= FILL;
                end
                FILL: begin
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                    state      <= COMPARE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage: refill from memory, or merge a write-hit word.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            data_arr[idx] <= mem_rd_blk;
            tag_arr[idx]  <= tag;
        end else if (state == COMPARE && is_hit && req_wr) begin
            data_arr[idx][wbit +: 32] <= req_data;
        end
    end

endmodule

// File: tb/tb_cache_data_ctrl.sv
// Self-checking bench: directed plan steps plus random traffic
// against a two-level byte-array model of cache and memory.
module tb_cache_data_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_en;
    logic         wr_en;
    logic [31:0]  addr;
    logic [31:0]  data_wr;
    logic [511:0] mem_rd_blk;
    logic [31:0]  mem_addr;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [511:0] mem_wr_blk;
    logic         hit;
    logic [31:0]  word_out;
    logic [7:0]   byte_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mmem [4096];
    logic [7:0]  cl   [16][64];
    logic [21:0] ct   [16];
    bit          cv   [16];
    bit          cd   [16];

    cache_data_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .addr       (addr),
        .data_wr    (data_wr),
        .mem_rd_blk (mem_rd_blk),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_blk (mem_wr_blk),
        .hit        (hit),
        .word_out   (word_out),
        .byte_out   (byte_out)
    );

    cache_data_ctrl_mem u_mem (
        .clk     (clk),
        .addr    (mem_addr),
        .rd_en   (mem_rd_en),
        .wr_en   (mem_wr_en),
        .wr_data (mem_wr_blk),
        .rd_data (mem_rd_blk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_invalidate();
        for (int i = 0; i < 16; i++) begin
            cv[i] = 1'b0;
            cd[i] = 1'b0;
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        #1;
        chk({tag, "_hit"}, 512'(hit), 512'(0));
        chk({tag, "_word"}, 512'(word_out), 512'(0));
        chk({tag, "_byte"}, 512'(byte_out), 512'(0));
        chk({tag, "_mrd"}, 512'(mem_rd_en), 512'(0));
        chk({tag, "_mwr"}, 512'(mem_wr_en), 512'(0));
        model_invalidate();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request: model predicts outcome, DUT is driven and compared.
    task automatic do_req(input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          idx;
        int          wb;
        int          elat;
        int          n;
        bit          ehit;
        bit          edirty;
        bit          saw_wr;
        bit          saw_rd;
        logic [21:0] tg;
        logic [31:0] evict;
        logic [31:0] fetch;
        logic [31:0] wr_a;
        logic [31:0] rd_a;
        logic [31:0] eword;
        logic [7:0]  ebyte;

        idx    = int'(a[9:6]);
        tg     = a[31:10];
        ehit   = cv[idx] && ct[idx] == tg;
        edirty = !ehit && cv[idx] && cd[idx];
        evict  = {ct[idx], a[9:6], 6'b0};
        fetch  = {a[31:6], 6'b0};
        elat   = ehit ? 2 : (edirty ? 6 : 5);
        if (!ehit) begin
            if (edirty) begin
                for (int k = 0; k < 64; k++)
                    mmem[int'(evict[11:0]) + k] = cl[idx][k];
            end
            for (int k = 0; k < 64; k++)
                cl[idx][k] = mmem[int'(fetch[11:0]) + k];
            cv[idx] = 1'b1;
            cd[idx] = 1'b0;
            ct[idx] = tg;
        end
        wb = int'({a[5:2], 2'b00});
        if (wr) begin
            for (int j = 0; j < 4; j++)
                cl[idx][wb + j] = d[8*j +: 8];
            cd[idx] = 1'b1;
        end
        eword = {cl[idx][wb+3], cl[idx][wb+2], cl[idx][wb+1], cl[idx][wb]};
        ebyte = cl[idx][int'(a[5:0])];

        @(negedge clk);
        wr_en   = wr;
        rd_en   = !wr;
        addr    = a;
        data_wr = d;
        @(posedge clk);
        #1;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        n      = 1;
        saw_wr = 1'b0;
        saw_rd = 1'b0;
        wr_a   = '0;
        rd_a   = '0;
        while (!hit && n < 20) begin
            if (mem_wr_en) begin
                saw_wr = 1'b1;
                wr_a   = mem_addr;
            end
            if (mem_rd_en) begin
                saw_rd = 1'b1;
                rd_a   = mem_addr;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 512'(n), 512'(elat));
        chk({tag, "_word"}, 512'(word_out), 512'(eword));
        chk({tag, "_byte"}, 512'(byte_out), 512'(ebyte));
        chk({tag, "_wb"}, 512'(saw_wr), 512'(edirty));
        chk({tag, "_fill"}, 512'(saw_rd), 512'(!ehit));
        if (edirty) chk({tag, "_wbaddr"}, 512'(wr_a), 512'(evict));
        if (!ehit) chk({tag, "_filladdr"}, 512'(rd_a), 512'(fetch));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 512'(hit), 512'(0));
    endtask

    initial begin
        bit          w;
        logic [31:0] a;

        for (int i = 0; i < 4096; i++) mmem[i] = 8'(i);
        model_invalidate();
        rst_n   = 1'b1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        addr    = '0;
        data_wr = '0;

        apply_reset("reset0");

        do_req(1'b0, 32'h0000_0000, 32'h0, "rd00");
        chk("rd00_lit", 512'(word_out), 512'(32'h0302_0100));

        do_req(1'b0, 32'h0000_0044, 32'h0, "rd44");
        chk("rd44_lit", 512'(word_out), 512'(32'h4746_4544));
        chk("rd44_litb", 512'(byte_out), 512'(8'h44));

        do_req(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, "wr04");
        do_req(1'b0, 32'h0000_0004, 32'h0, "rd04");
        chk("rd04_lit", 512'(word_out), 512'(32'hDEAD_BEEF));
        chk("rd04_litb", 512'(byte_out), 512'(8'hEF));

        do_req(1'b0, 32'h0000_0400, 32'h0, "rd400");
        chk("rd400_lit", 512'(word_out), 512'(32'h0302_0100));

        do_req(1'b0, 32'h0000_0004, 32'h0, "rd04b");
        chk("rd04b_lit", 512'(word_out), 512'(32'hDEAD_BEEF));

        apply_reset("reset1");
        do_req(1'b0, 32'h0000_1000, 32'h0, "rd1000");
        chk("rd1000_lit", 512'(word_out), 512'(32'h0302_0100));

        // Abort a miss while it sits in FILL.
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 32'h0000_0080;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_alloc", 512'(mem_rd_en), 512'(1));
        chk("abort_addr", 512'(mem_addr), 512'(32'h80));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_hit", 512'(hit), 512'(0));
        chk("abort_word", 512'(word_out), 512'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("abort_hold", 512'(hit), 512'(0));
        model_invalidate();
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h0000_0000, 32'h0, "post_abort");
        do_req(1'b0, 32'h0000_0080, 32'h0, "post_abort80");

        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 1) == 1);
            a = {19'b0, 3'($urandom_range(0, 7)), 2'b0,
                 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
            do_req(w, a, $urandom, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_data_ctrl.md
# cache_data_ctrl

Direct-mapped, write-back, write-allocate data cache for a single requester, paired with a block-wide backing memory model (`mem`). The cache side (`cache_data`) takes word reads and writes and returns the addressed word and byte. It fills and evicts whole 64-byte blocks over a block-wide memory port. `mem` is the synchronous backing store on the other side of that port.

## Interface
**Parameters**
- PA_WIDTH, 32: physical address width.
- WRD_WIDTH, 32: word width.
- BYTE, 8: byte width.
- BLK_WIDTH, 512: block width (64 B).
- NUM_LINES, 16: cache lines; index = addr[9:6], tag = addr[31:10].
- MEM_BLOCKS, 64: blocks in `mem` (4 KiB); block index = addr[11:6].

**Ports of `cache_data`**
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- rd_en, in, 1: read request.
- wr_en, in, 1: write request; wins over rd_en.
- addr, in, PA_WIDTH: byte address.
- data_wr, in, WRD_WIDTH: write word.
- mem_rd_blk, in, BLK_WIDTH: block returned by mem.
- mem_addr, out, PA_WIDTH: block-aligned memory address, low 6 bits 0.
- mem_rd_en, out, 1: memory block read.
- mem_wr_en, out, 1: memory block write.
- mem_wr_blk, out, BLK_WIDTH: evicted block.
- hit, out, 1: one-cycle pulse; request complete, outputs valid.
- word_out, out, WRD_WIDTH: word at addr[5:2].
- byte_out, out, BYTE: byte at addr[5:0].

**Ports of `mem`**: clk; addr (PA_WIDTH); rd_en; wr_en; wr_data (BLK_WIDTH); rd_data (BLK_WIDTH, registered).

## Operation
- Little-endian: byte k of a block occupies bits [8k+7:8k].
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL.
  - IDLE: if wr_en or rd_en is high, latch addr, data_wr and the op, then go to COMPARE. Requests are sampled only in IDLE; a held rd_en re-issues the request.
  - COMPARE: if valid and the tag matches, register word_out/byte_out, pulse hit, and go to IDLE. On a write hit, merge data_wr into word addr[5:2], set dirty, and drive word_out = data_wr. On a miss, go to WRITEBACK if the victim line is dirty, else to ALLOCATE.
  - WRITEBACK: drive mem_wr_en=1, mem_addr={victim tag, index, 6'b0}, mem_wr_blk=victim line; go to ALLOCATE.
  - ALLOCATE: drive mem_rd_en=1, mem_addr={addr[31:6], 6'b0}; go to FILL.
  - FILL: load mem_rd_blk into the line, set valid, tag=addr[31:10], clear dirty; go to COMPARE, which then hits.
- mem_* outputs are Moore outputs of state and are 0 outside WRITEBACK/ALLOCATE.
- `mem` behaviour:
  - Write: at the clock edge with wr_en, store the block at index addr[11:6].
  - Read: at the clock edge with rd_en, rd_data <= block; rd_data otherwise holds.
  - Addresses alias modulo 4 KiB.
  - Initial contents: byte at address A = A[7:0]. No reset port.

## Timing
- Reset: state=IDLE; all valid/dirty bits cleared; hit=0, word_out=0, byte_out=0; mem_rd_en=mem_wr_en=0. Data arrays are not cleared.
- Reset mid-operation aborts the FSM. A WRITEBACK already clocked into `mem` persists; otherwise memory is untouched.
- Latency, counted from the IDLE edge that samples the request to the edge that raises hit:
  - hit: 2 cycles.
  - clean miss: 5 cycles (IDLE, COMPARE, ALLOCATE, FILL, COMPARE).
  - dirty miss: 6 cycles.
- hit is high for exactly one cycle. word_out and byte_out hold their value until the next completion.
- `mem` read data is valid one edge after rd_en and is consumed in FILL.

## Structure
- Shared package (`macros.sv`): PA_WIDTH, WRD_WIDTH, BYTE, BLK_WIDTH, NUM_LINES, offset/index/tag field widths, FSM state enum.
- `cache_data`: FSM plus tag/valid/dirty/data arrays.
- `mem`: separate sub-module instantiated beside it, not inside it.

## Test plan
- Reset, then read 0x00 → mem_rd_en pulse with mem_addr=0x00; 5 cycles later hit=1, word_out=0x03020100, byte_out=0x00.
- Read 0x44 after the 0x00 fill → miss on index 1; word_out=0x47464544, byte_out=0x44.
- Write 0x04, data 0xDEADBEEF (line resident) → hit after 2 cycles. Then read 0x04 → hit after 2 cycles, word_out=0xDEADBEEF, byte_out=0xEF.
- Then read 0x400 (same index 0, dirty) → mem_wr_en with mem_addr=0x00, then a fill from 0x400; word_out=0x03020100. Then read 0x04 → miss; word_out=0xDEADBEEF, fetched from memory.
- Read 0x1000 with a cold cache → `mem` aliases it to block 0; word_out=0x03020100.
- Assert rst_n low during FILL → hit stays 0, valid cleared. After release, read 0x00 misses again with full miss latency.
